// File: rtl/led_pattern_gen_pkg.sv
// rtl/led_pattern_gen_pkg.sv - mode and direction codes shared by the LED pattern generator
package led_pattern_gen_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_ROT_L  = 3'd0,
      MODE_ROT_R  = 3'd1,
      MODE_BOUNCE = 3'd2,
      MODE_BLINK  = 3'd3,
      MODE_COUNT  = 3'd4
   } mode_e;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   // Unused codes 5-7 fall back to left rotation.
   function automatic mode_e map_mode(input logic [MODE_W-1:0] m);
      return (m > 3'd4) ? MODE_ROT_L : mode_e'(m);
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - prescaler with run/pause and speed select, emits a registered step tick
module led_tick_gen #(
   parameter int CNT_W   = 25,
   parameter int CNT_MAX = 24_999_999
) (
   input  logic       clk_50,
   input  logic       reset,
   input  logic       run,
   input  logic [1:0] speed,
   output logic       o_step,
   output logic       o_tick
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(CNT_MAX);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_term;

   // >= lets a speed-up mid-count step on the very next cycle.
   assign w_term = MAX_CNT >> speed;
   assign o_step = run && (r_cnt >= w_term);

   always_ff @(posedge clk_50 or negedge reset) begin
      if (!reset) begin
         r_cnt  <= '0;
         o_tick <= 1'b0;
      end else if (!run) begin
         o_tick <= 1'b0;
      end else if (o_step) begin
         r_cnt  <= '0;
         o_tick <= 1'b1;
      end else begin
         r_cnt  <= r_cnt + CNT_W'(1);
         o_tick <= 1'b0;
      end
   end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-mode active-low LED pattern generator
module led_pattern_gen
   import led_pattern_gen_pkg::*;
#(
   parameter int LED_NUM = 4,
   parameter int CNT_W   = 25,
   parameter int CNT_MAX = 24_999_999
) (
   input  logic               clk_50,
   input  logic               reset,
   input  logic               run,
   input  logic [1:0]         speed,
   input  logic [2:0]         mode,
   output logic [LED_NUM-1:0] led,
   output logic               tick,
   output logic [2:0]         cur_mode
);

   localparam logic [LED_NUM-1:0] SEED_L   = {{(LED_NUM-1){1'b1}}, 1'b0};
   localparam logic [LED_NUM-1:0] SEED_R   = {1'b0, {(LED_NUM-1){1'b1}}};
   localparam logic [LED_NUM-1:0] SEED_OFF = {LED_NUM{1'b1}};

   logic [LED_NUM-1:0] r_led;
   mode_e              r_mode;
   dir_e               r_dir;

   logic               w_step;
   mode_e              w_req;
   logic [LED_NUM-1:0] w_led_next;
   dir_e               w_dir_next;
   logic [LED_NUM-1:0] w_shl;
   logic [LED_NUM-1:0] w_shr;

   led_tick_gen #(
      .CNT_W   (CNT_W),
      .CNT_MAX (CNT_MAX)
   ) u_tick_gen (
      .clk_50 (clk_50),
      .reset  (reset),
      .run    (run),
      .speed  (speed),
      .o_step (w_step),
      .o_tick (tick)
   );

   assign w_req = map_mode(mode);
   assign w_shl = {r_led[LED_NUM-2:0], 1'b1};
   assign w_shr = {1'b1, r_led[LED_NUM-1:1]};

   always_comb begin
      w_led_next = r_led;
      w_dir_next = r_dir;
      if (w_req != r_mode) begin
         w_dir_next = DIR_LEFT;
         case (w_req)
            MODE_ROT_L, MODE_BOUNCE: w_led_next = SEED_L;
            MODE_ROT_R:              w_led_next = SEED_R;
            default:                 w_led_next = SEED_OFF;
         endcase
      end else begin
         case (r_mode)
            MODE_ROT_L: w_led_next = {r_led[LED_NUM-2:0], r_led[LED_NUM-1]};
            MODE_ROT_R: w_led_next = {r_led[0], r_led[LED_NUM-1:1]};
            MODE_BOUNCE: begin
               // Flip direction as the lit LED lands on an end so it stays there one step.
               if (r_dir == DIR_LEFT) begin
                  w_led_next = w_shl;
                  if (!w_shl[LED_NUM-1]) w_dir_next = DIR_RIGHT;
               end else begin
                  w_led_next = w_shr;
                  if (!w_shr[0]) w_dir_next = DIR_LEFT;
               end
            end
            MODE_BLINK: w_led_next = ~r_led;
            MODE_COUNT: w_led_next = ~(~r_led + LED_NUM'(1));
            default:    w_led_next = r_led;
         endcase
      end
   end

   always_ff @(posedge clk_50 or negedge reset) begin
      if (!reset) begin
         r_led  <= SEED_L;
         r_mode <= MODE_ROT_L;
         r_dir  <= DIR_LEFT;
      end else if (w_step) begin
         r_led  <= w_led_next;
         r_mode <= w_req;
         r_dir  <= w_dir_next;
      end
   end

   assign led      = r_led;
   assign cur_mode = r_mode;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - scoreboard bench for led_pattern_gen with LED_NUM=4, CNT_MAX=3
module tb_led_pattern_gen;

   logic       clk;
   logic       reset;
   logic       run;
   logic [1:0] speed;
   logic [2:0] mode;
   logic [3:0] led;
   logic       tick;
   logic [2:0] cur_mode;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] led;
      logic [2:0] mode;
      int         gap;
   } exp_t;

   exp_t sb[$];

   led_pattern_gen #(
      .LED_NUM (4),
      .CNT_W   (25),
      .CNT_MAX (3)
   ) dut (
      .clk_50   (clk),
      .reset    (reset),
      .run      (run),
      .speed    (speed),
      .mode     (mode),
      .led      (led),
      .tick     (tick),
      .cur_mode (cur_mode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] l, input logic [2:0] m, input int gap);
      exp_t e;
      e.led  = l;
      e.mode = m;
      e.gap  = gap;
      sb.push_back(e);
   endtask

   // Wait (bounded) for the next tick and compare against the oldest expectation.
   task automatic wait_step(input string tag);
      int   n;
      exp_t e;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tick !== 1'b1 && n < 64);
      check({tag, " tick"}, {31'd0, tick}, 32'd1);
      if (sb.size() == 0) begin
         check({tag, " scoreboard"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         if (tick === 1'b1) begin
            check({tag, " led"}, {28'd0, led}, {28'd0, e.led});
            check({tag, " cur_mode"}, {29'd0, cur_mode}, {29'd0, e.mode});
            if (e.gap != 0) check({tag, " gap"}, n, e.gap);
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      run   = 1'b1;
      speed = 2'd0;
      mode  = 3'd0;
      repeat (3) @(negedge clk);
      check("reset led", {28'd0, led}, 32'h0000_000E);
      check("reset tick", {31'd0, tick}, 32'd0);
      check("reset cur_mode", {29'd0, cur_mode}, 32'd0);
      reset = 1'b1;

      // ROT_L, period 4
      push(4'b1101, 3'd0, 4);
      push(4'b1011, 3'd0, 4);
      push(4'b0111, 3'd0, 4);
      push(4'b1110, 3'd0, 4);
      for (int i = 0; i < 4; i++) wait_step("rotl");

      // BOUNCE
      mode = 3'd2;
      push(4'b1110, 3'd2, 4);
      push(4'b1101, 3'd2, 4);
      push(4'b1011, 3'd2, 4);
      push(4'b0111, 3'd2, 4);
      push(4'b1011, 3'd2, 4);
      push(4'b1101, 3'd2, 4);
      push(4'b1110, 3'd2, 4);
      push(4'b1101, 3'd2, 4);
      for (int i = 0; i < 8; i++) wait_step("bounce");

      // COUNT: reload then 16 steps wrapping back to all-off
      mode = 3'd4;
      push(4'b1111, 3'd4, 4);
      for (int v = 1; v <= 16; v++) begin
         logic [3:0] cv;
         cv = 4'(v);
         push(~cv, 3'd4, 4);
      end
      for (int i = 0; i < 17; i++) wait_step("count");

      // Speed up at cnt=2: step on the next cycle, then every cycle
      @(negedge clk);
      @(negedge clk);
      speed = 2'd2;
      push(4'b1110, 3'd4, 1);
      push(4'b1101, 3'd4, 1);
      push(4'b1100, 3'd4, 1);
      for (int i = 0; i < 3; i++) wait_step("speed2");
      speed = 2'd1;
      push(4'b1011, 3'd4, 2);
      push(4'b1010, 3'd4, 2);
      for (int i = 0; i < 2; i++) wait_step("speed1");
      speed = 2'd0;
      push(4'b1001, 3'd4, 4);
      wait_step("speed0");

      // Pause at cnt=1 for 10 cycles
      @(negedge clk);
      run = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("pause tick", {31'd0, tick}, 32'd0);
         check("pause led", {28'd0, led}, 32'h0000_0009);
      end
      run = 1'b1;
      push(4'b1000, 3'd4, 3);
      wait_step("resume");

      // BLINK, then async reset with all LEDs lit
      mode = 3'd3;
      push(4'b1111, 3'd3, 4);
      push(4'b0000, 3'd3, 4);
      for (int i = 0; i < 2; i++) wait_step("blink");
      reset = 1'b0;
      #1;
      check("async reset led", {28'd0, led}, 32'h0000_000E);
      check("async reset cur_mode", {29'd0, cur_mode}, 32'd0);
      check("async reset tick", {31'd0, tick}, 32'd0);
      @(negedge clk);
      mode = 3'd7;
      @(negedge clk);
      reset = 1'b1;

      // Mode 7 acts as ROT_L: advances without a reload
      push(4'b1101, 3'd0, 4);
      push(4'b1011, 3'd0, 4);
      for (int i = 0; i < 2; i++) wait_step("mode7");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
